// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the approximate signed multiplier pipeline.
// Recovery level encodings and the elaboration-time parameter legality check.
package approx_mult_pkg;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_BIAS = 2'd1;
    localparam logic [1:0] LVL_COL  = 2'd2;

    // Level 3 is decoded exactly like LVL_COL.
    function automatic bit trunc_cols_legal(int unsigned width, int unsigned trunc_cols);
        return (width >= 4) && (trunc_cols <= width);
    endfunction

endpackage

// File: rtl/approx_pp_sum.sv
// Combinational truncated sign-magnitude partial-product array plus recovery term.
// Outputs the kept-column magnitude sum and the selected compensation value separately.
module approx_pp_sum
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TRUNC_COLS = 8
) (
    input  logic [WIDTH-1:0]   mag_a,
    input  logic [WIDTH-1:0]   mag_b,
    input  logic [1:0]         level,
    output logic [2*WIDTH-1:0] m,
    output logic [2*WIDTH-1:0] r
);

    localparam int unsigned PW = 2 * WIDTH;

    // Clearing the low product columns of each shifted row drops every a_j*b_k with j+k < TRUNC_COLS.
    localparam logic [PW-1:0] COL_MASK = {PW{1'b1}} << TRUNC_COLS;

    always_comb begin
        m = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            if (mag_a[j]) begin
                m = m + ((PW'(mag_b) << j) & COL_MASK);
            end
        end
    end

    if (TRUNC_COLS == 0) begin : gen_exact
        logic unused_level;
        assign unused_level = ^level;
        assign r = '0;
    end else begin : gen_recover
        localparam int TOP = int'(TRUNC_COLS) - 1;

        logic [PW-1:0] col_cnt;

        // Population count of the highest dropped column, without carries from below.
        always_comb begin
            col_cnt = '0;
            for (int j = 0; j <= TOP; j++) begin
                col_cnt = col_cnt + PW'(mag_a[j] & mag_b[TOP-j]);
            end
        end

        always_comb begin
            r = '0;
            case (level)
                LVL_NONE: r = '0;
                LVL_BIAS: r = PW'(1) << TOP;
                LVL_COL:  r = col_cnt << TOP;
                default:  r = col_cnt << TOP;
            endcase
        end
    end

endmodule

// File: rtl/approx_signed_mult_pipe.sv
// Three-stage valid/ready pipelined approximate signed multiplier with per-transaction
// recovery level, pass-through tag and a count of delivered results.
module approx_signed_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TRUNC_COLS = 8,
    parameter int unsigned TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         level,
    input  logic [TAG_W-1:0]   tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic [TAG_W-1:0]   y_tag,
    output logic [15:0]        done_cnt
);

    localparam int unsigned PW = 2 * WIDTH;

    if (!trunc_cols_legal(WIDTH, TRUNC_COLS)) begin : gen_param_check
        $error("approx_signed_mult_pipe: WIDTH must be >= 4 and TRUNC_COLS <= WIDTH");
    end

    // Stage 1: magnitudes, sign, zero flag, level, tag
    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic               sign1_q, zero1_q;
    logic [1:0]         level1_q;
    logic [TAG_W-1:0]   tag1_q;

    // Stage 2: truncated magnitude and recovery term
    logic               v2_q, v2_d;
    logic [PW-1:0]      m_q, r_q;
    logic               sign2_q, zero2_q;
    logic [TAG_W-1:0]   tag2_q;

    // Stage 3: signed result
    logic               v3_q, v3_d;
    logic [PW-1:0]      y_q, y_d;
    logic [TAG_W-1:0]   y_tag_q;
    logic [15:0]        done_cnt_q;

    logic               adv1, adv2, in_xfer, out_xfer;
    logic [WIDTH-1:0]   mag_a_d, mag_b_d;
    logic [PW-1:0]      m_d, r_d, sum;

    always_comb begin
        adv2     = v2_q && (!v3_q || out_ready);
        adv1     = v1_q && (!v2_q || adv2);
        in_ready = !v1_q || adv1;
        in_xfer  = in_valid && in_ready;
        out_xfer = v3_q && out_ready;

        v1_d = in_xfer ? 1'b1 : (adv1 ? 1'b0 : v1_q);
        v2_d = adv1    ? 1'b1 : (adv2 ? 1'b0 : v2_q);
        v3_d = adv2    ? 1'b1 : (out_xfer ? 1'b0 : v3_q);
    end

    // Two's-complement negate of the most negative value yields 2^(WIDTH-1) as unsigned.
    always_comb begin
        mag_a_d = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        mag_b_d = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    end

    approx_pp_sum #(
        .WIDTH      (WIDTH),
        .TRUNC_COLS (TRUNC_COLS)
    ) u_pp_sum (
        .mag_a (mag_a_q),
        .mag_b (mag_b_q),
        .level (level1_q),
        .m     (m_d),
        .r     (r_d)
    );

    always_comb begin
        sum = m_q + r_q;
        y_d = '0;
        if (!zero2_q) begin
            y_d = sign2_q ? (~sum + PW'(1)) : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            sign1_q    <= 1'b0;
            zero1_q    <= 1'b0;
            level1_q   <= '0;
            tag1_q     <= '0;
            v2_q       <= 1'b0;
            m_q        <= '0;
            r_q        <= '0;
            sign2_q    <= 1'b0;
            zero2_q    <= 1'b0;
            tag2_q     <= '0;
            v3_q       <= 1'b0;
            y_q        <= '0;
            y_tag_q    <= '0;
            done_cnt_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (in_xfer) begin
                mag_a_q  <= mag_a_d;
                mag_b_q  <= mag_b_d;
                sign1_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                zero1_q  <= (a == '0) || (b == '0);
                level1_q <= level;
                tag1_q   <= tag;
            end
            if (adv1) begin
                m_q     <= m_d;
                r_q     <= r_d;
                sign2_q <= sign1_q;
                zero2_q <= zero1_q;
                tag2_q  <= tag1_q;
            end
            // Held while the consumer stalls so y/y_tag stay stable until transfer.
            if (adv2) begin
                y_q     <= y_d;
                y_tag_q <= tag2_q;
            end
            if (out_xfer) begin
                done_cnt_q <= done_cnt_q + 16'd1;
            end
        end
    end

    assign out_valid = v3_q;
    assign y         = y_q;
    assign y_tag     = y_tag_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: doc/approx_signed_mult_pipe.md
# approx_signed_mult_pipe

Pipelined, parametrised approximate signed multiplier with run-time selectable error recovery and valid/ready flow control. It is the successor of the combinational approximate signed multiplier. Power is saved by dropping low partial-product columns of a sign-magnitude array, and a per-transaction recovery level trades accuracy for power. It sits between operand producers and downstream accumulate/filter logic, and carries a user tag so out-of-band context stays aligned with results.

## Interface
- WIDTH, 16: operand width (signed, ≥4).
- TRUNC_COLS, 8: number of least-significant partial-product columns omitted; legal range 0..WIDTH.
- TAG_W, 4: width of the pass-through tag.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  signed operand.
- b  in  WIDTH  signed operand.
- level  in  2  recovery level: 0 none, 1 bias, 2 column, 3 treated as 2.
- tag  in  TAG_W  user tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  2*WIDTH  signed approximate product.
- y_tag  out  TAG_W  tag of the result on y.
- done_cnt  out  16  count of results transferred out; wraps at 65535→0.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Magnitudes |a| and |b| are held as WIDTH-bit unsigned values, so −2^(WIDTH−1) maps to 2^(WIDTH−1). Sign s = a[MSB] ^ b[MSB].
- Truncated magnitude: M = Σ a_j·b_k·2^(j+k) over all j,k with j+k ≥ TRUNC_COLS.
- Recovery term R, used only when TRUNC_COLS > 0; otherwise R = 0 at every level:
  - level 0: R = 0.
  - level 1: R = 2^(TRUNC_COLS−1), a constant bias.
  - level 2/3: R = 2^(TRUNC_COLS−1) · Σ_{j+k=TRUNC_COLS−1} a_j·b_k, i.e. the top dropped column is restored exactly with no carry-in from below.
- Result: if a == 0 or b == 0, y = 0 at every level. Otherwise y = s ? −(M+R) : (M+R), sign-extended to 2*WIDTH bits.
- M+R ≤ 2^(2·WIDTH−2) + 2^(WIDTH+TRUNC_COLS−1), which always fits in 2*WIDTH signed. No saturation is needed.
- level and tag are sampled with the operands. A level change between transactions takes effect per transaction, with no pipeline flush.
- done_cnt increments on each output transfer.

## Timing
- Three-stage pipeline:
  - S1 registers magnitudes, sign, zero flag, level and tag.
  - S2 registers M and R.
  - S3 applies the sign and drives y, y_tag and out_valid.
- Latency is 3 cycles from input transfer to out_valid with no back-pressure. Throughput is 1 result per cycle.
- A stage advances when its successor is empty or is advancing in the same cycle.
- in_ready = !v1 || advance1. It is combinational on out_ready through the stage valids; no combinational path exists from in_valid to in_ready.
- When out_valid is high and out_ready is low, y and y_tag hold stable until transfer. A full pipeline holds three in-flight results, and in_ready deasserts.
- Simultaneous output transfer and input transfer in the same cycle on a full pipeline is legal and loses nothing.
- Reset (rst_n low at an edge) clears all stage valids, out_valid = 0, y = 0, y_tag = 0 and done_cnt = 0. In-flight data is discarded. in_ready is 1 in the first cycle after reset release.

## Structure
- Package approx_mult_pkg holds the level constants (LVL_NONE = 0, LVL_BIAS = 1, LVL_COL = 2) and the function for the legal TRUNC_COLS range check.
- Sub-module approx_pp_sum holds the combinational truncated magnitude array plus the recovery term. It is instantiated once between S1 and S2.
- The top level holds the pipeline registers, the handshake and done_cnt.

## Test plan
All scenarios use WIDTH=8, TRUNC_COLS=4, TAG_W=4.
- Truncation: a=3, b=5 at level 0/1/2 -> y=0/8/8. a=−3, b=5 at level 1 -> y=−8. Each result appears 3 cycles after transfer.
- Extremes: a=−128, b=−128 at level 0/1/2 -> y=16384/16392/16384. a=127, b=127 at level 0/1/2 -> y=16080/16088/16112.
- Zero: a=0, b=−7 at level 1 -> y=0.
- Back-pressure: stream 6 operand pairs with out_ready held low for 5 cycles.
  - in_ready falls after 3 accepts.
  - y and y_tag stay stable while out_ready is low.
  - All 6 results arrive in order with matching tags.
  - done_cnt=6 at the end.
- Reset mid-stream: with 2 results in flight, pulse rst_n low for 1 cycle -> out_valid=0, done_cnt=0, and no stale result emerges afterwards.
- Exact mode: rebuild with TRUNC_COLS=0, then drive random a, b at all levels -> y = a*b bit-exact.
